// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the parametrised register file.
//   clr_state_t : bulk-clear FSM state encoding (IDLE, CLEAR, DONE)
//   DATA_W_DEF  : default register width
//   DEPTH_DEF   : default number of registers
package reg_file_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/reg_file_param_decoder.sv
// Combinational binary-to-one-hot decoder with an enable.
//   sel    : binary select, N_SEL bits
//   en     : when low, the output is all zeros
//   onehot : 2**N_SEL bits, exactly one set when en is high
module decoder_param #(
    parameter int unsigned N_SEL = 5
) (
    input  logic [N_SEL-1:0]    sel,
    input  logic                en,
    output logic [2**N_SEL-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, two combinational read
// ports, and a sequential bulk-clear engine sweeping one entry per cycle.
//   clk, reset          : clock (rising edge), async active-high reset
//   wr_en/addr/data     : write port, honoured only while the FSM is IDLE
//   rd_addr0/rd_data0   : read port 0, combinational
//   rd_addr1/rd_data1   : read port 1, combinational
//   clr_req             : start a bulk clear (sampled in IDLE only)
//   clr_busy            : sweep in progress (registered)
//   clr_done            : one-cycle pulse after the last entry is cleared
// Optional build macro REG_FILE_BYPASS_EN enables same-cycle
// write-to-read forwarding on both read ports.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter  int unsigned DATA_W   = DATA_W_DEF,
    parameter  int unsigned DEPTH    = DEPTH_DEF,
    parameter  bit          ZERO_REG = 1'b1,
    localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr0,
    output logic [DATA_W-1:0] rd_data0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    clr_state_t        state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              sweeping;
    logic              dec_en;
    logic [ADDR_W-1:0] dec_sel;
    logic [DATA_W-1:0] wr_value;
    logic [DEPTH-1:0]  we_vec;

    // Bulk-clear FSM; terminal compare on ptr so no entry is swept twice.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        ptr      <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (ptr == LAST_PTR) begin
                        state    <= DONE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

    // The sweep borrows the write path: pointer and zero data replace the port.
    assign sweeping = (state == CLEAR);
    assign dec_sel  = sweeping ? ptr : wr_addr;
    assign dec_en   = sweeping || ((state == IDLE) && wr_en);
    assign wr_value = sweeping ? '0 : wr_data;

    decoder_param #(
        .N_SEL (ADDR_W)
    ) u_wr_dec (
        .sel    (dec_sel),
        .en     (dec_en),
        .onehot (we_vec)
    );

    // Storage; entry 0 never loads when it is the hardwired zero register.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                mem[g] <= '0;
            end else if (we_vec[g] && !(ZERO_REG && (g == 0))) begin
                mem[g] <= wr_value;
            end
        end
    end

`ifdef REG_FILE_BYPASS_EN
    logic fwd_ok;
    assign fwd_ok = (state == IDLE) && wr_en && !(ZERO_REG && (wr_addr == '0));
`endif

    // Read ports, each resolved independently.
    always_comb begin
        rd_data0 = mem[rd_addr0];
        rd_data1 = mem[rd_addr1];
        if (ZERO_REG && (rd_addr0 == '0)) begin
            rd_data0 = '0;
        end
        if (ZERO_REG && (rd_addr1 == '0)) begin
            rd_data1 = '0;
        end
`ifdef REG_FILE_BYPASS_EN
        if (fwd_ok && (rd_addr0 == wr_addr)) begin
            rd_data0 = wr_data;
        end
        if (fwd_ok && (rd_addr1 == wr_addr)) begin
            rd_data1 = wr_data;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_param.sv
module tb_reg_file_param;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr0;
    logic [31:0] rd_data0;
    logic [4:0]  rd_addr1;
    logic [31:0] rd_data1;
    logic        clr_req;
    logic        clr_busy;
    logic        clr_done;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;
    logic [31:0] got;

    reg_file_param dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr0 (rd_addr0),
        .rd_data0 (rd_data0),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic peek0(input logic [4:0] a, output logic [31:0] d);
        rd_addr0 = a; #1; d = rd_data0;
    endtask

    task automatic peek1(input logic [4:0] a, output logic [31:0] d);
        rd_addr1 = a; #1; d = rd_data1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #12;
        @(negedge clk); reset = 1'b0;
        do_write(5'd4, 32'h55);
        do_write(5'd20, 32'h77);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        exp = exp_q.pop_front(); got = {31'd0, clr_busy};
        checks++; if (got !== exp) begin failures++; $display("FAIL reset_busy got=%h exp=%h", got, exp); end
        exp = exp_q.pop_front(); got = {31'd0, clr_done};
        checks++; if (got !== exp) begin failures++; $display("FAIL reset_done got=%h exp=%h", got, exp); end
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(32'd0); exp_q.push_back(32'd0);
            peek0(5'(i), got); exp = exp_q.pop_front();
            checks++; if (got !== exp) begin failures++; $display("FAIL reset_rd0[%0d] got=%h exp=%h", i, got, exp); end
            peek1(5'(i), got); exp = exp_q.pop_front();
            checks++; if (got !== exp) begin failures++; $display("FAIL reset_rd1[%0d] got=%h exp=%h", i, got, exp); end
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_write_read;
        do_write(5'd5, 32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        do_write(5'd31, 32'h12345678);
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'd0);
        peek0(5'd5, got); exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL wr_rd_addr5 got=%h exp=%h", got, exp); end
        peek1(5'd31, got); exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL wr_rd_addr31 got=%h exp=%h", got, exp); end
        peek0(5'd6, got); exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL wr_rd_addr6 got=%h exp=%h", got, exp); end
        // same address on both ports
        exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF);
        peek0(5'd5, got); exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL same_addr_p0 got=%h exp=%h", got, exp); end
        peek1(5'd5, got); exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL same_addr_p1 got=%h exp=%h", got, exp); end
    endtask

    task automatic test_zero_reg;
        do_write(5'd0, 32'hFFFFFFFF);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        peek0(5'd0, got); exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL zero_reg_p0 got=%h exp=%h", got, exp); end
        peek1(5'd0, got); exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL zero_reg_p1 got=%h exp=%h", got, exp); end
    endtask

    task automatic test_bulk_clear;
        int busy_cnt;
        int cyc;
        bit done_seen;
        for (int i = 0; i < 32; i++) do_write(5'(i), 32'(i + 1));
        @(negedge clk); clr_req = 1'b1;
        @(negedge clk); clr_req = 1'b0;
        busy_cnt = 0; cyc = 0; done_seen = 1'b0;
        while (!done_seen && cyc < 200) begin
            if (clr_done) begin
                done_seen = 1'b1;
                exp_q.push_back(32'd0); got = {31'd0, clr_busy}; exp = exp_q.pop_front();
                checks++; if (got !== exp) begin failures++; $display("FAIL clr_busy_at_done got=%h exp=%h", got, exp); end
            end else begin
                if (clr_busy) busy_cnt++;
                if (busy_cnt == 3 && clr_busy) begin
                    exp_q.push_back(32'd0); exp_q.push_back(32'd11);
                    peek0(5'd1, got); exp = exp_q.pop_front();
                    checks++; if (got !== exp) begin failures++; $display("FAIL sweep3_addr1 got=%h exp=%h", got, exp); end
                    peek1(5'd10, got); exp = exp_q.pop_front();
                    checks++; if (got !== exp) begin failures++; $display("FAIL sweep3_addr10 got=%h exp=%h", got, exp); end
                    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hAA; clr_req = 1'b1;
                end else if (busy_cnt == 4 && clr_busy) begin
                    wr_en = 1'b0; clr_req = 1'b0;
                    exp_q.push_back(32'd8);
                    peek0(5'd7, got); exp = exp_q.pop_front();
                    checks++; if (got !== exp) begin failures++; $display("FAIL wr_during_busy_addr7 got=%h exp=%h", got, exp); end
                end
                @(negedge clk);
            end
            cyc++;
        end
        exp_q.push_back(32'd1); got = {31'd0, done_seen}; exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL clr_done_seen got=%h exp=%h", got, exp); end
        exp_q.push_back(32'd32); got = 32'(busy_cnt); exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL busy_cycles got=%0d exp=%0d", got, exp); end
        @(negedge clk);
        exp_q.push_back(32'd0); got = {30'd0, clr_busy, clr_done}; exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL after_done_busy_done got=%h exp=%h", got, exp); end
        @(negedge clk);
        exp_q.push_back(32'd0); got = {31'd0, clr_busy}; exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL clr_req_not_queued got=%h exp=%h", got, exp); end
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(32'd0);
            peek0(5'(i), got); exp = exp_q.pop_front();
            checks++; if (got !== exp) begin failures++; $display("FAIL cleared[%0d] got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_reset_mid_sweep;
        int busy_cnt;
        int cyc;
        int done_cnt;
        bit done_seen;
        do_write(5'd25, 32'h2525);
        // write and clear request in the same IDLE cycle
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33330003; clr_req = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; clr_req = 1'b0;
        exp_q.push_back(32'h33330003);
        peek0(5'd3, got); exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL wr_with_clr_req got=%h exp=%h", got, exp); end
        busy_cnt = 0; cyc = 0;
        while (clr_busy && busy_cnt < 9 && cyc < 100) begin
            busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        exp_q.push_back(32'd1); got = {31'd0, clr_busy}; exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL busy_at_cycle10 got=%h exp=%h", got, exp); end
        #2 reset = 1'b1;
        #1;
        exp_q.push_back(32'd0); got = {30'd0, clr_busy, clr_done}; exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL abort_busy_done got=%h exp=%h", got, exp); end
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(32'd0);
            peek1(5'(i), got); exp = exp_q.pop_front();
            checks++; if (got !== exp) begin failures++; $display("FAIL abort_entry[%0d] got=%h exp=%h", i, got, exp); end
        end
        @(negedge clk); reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (clr_done || clr_busy) done_cnt++;
        end
        exp_q.push_back(32'd0); got = 32'(done_cnt); exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL no_done_after_abort got=%0d exp=%0d", got, exp); end
        // a fresh sweep runs the full length
        do_write(5'd30, 32'h3030);
        @(negedge clk); clr_req = 1'b1;
        @(negedge clk); clr_req = 1'b0;
        busy_cnt = 0; cyc = 0; done_seen = 1'b0;
        while (!done_seen && cyc < 200) begin
            if (clr_done) done_seen = 1'b1;
            else begin
                if (clr_busy) busy_cnt++;
                @(negedge clk);
            end
            cyc++;
        end
        exp_q.push_back(32'd1); got = {31'd0, done_seen}; exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL resweep_done got=%h exp=%h", got, exp); end
        exp_q.push_back(32'd32); got = 32'(busy_cnt); exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL resweep_cycles got=%0d exp=%0d", got, exp); end
        @(negedge clk);
        exp_q.push_back(32'd0);
        peek0(5'd30, got); exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL resweep_addr30 got=%h exp=%h", got, exp); end
    endtask

    task automatic test_bypass;
        do_write(5'd9, 32'h11);
        @(negedge clk);
        rd_addr0 = 5'd9; rd_addr1 = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFEF00D;
`ifdef REG_FILE_BYPASS_EN
        exp_q.push_back(32'hCAFEF00D); exp_q.push_back(32'hCAFEF00D);
`else
        exp_q.push_back(32'h11); exp_q.push_back(32'h11);
`endif
        #1;
        got = rd_data0; exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL bypass_p0 got=%h exp=%h", got, exp); end
        got = rd_data1; exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL bypass_p1 got=%h exp=%h", got, exp); end
        @(negedge clk);
        wr_en = 1'b0;
        exp_q.push_back(32'hCAFEF00D);
        #1;
        got = rd_data0; exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL post_write_p0 got=%h exp=%h", got, exp); end
        // address 0 is never forwarded
        @(negedge clk);
        rd_addr0 = 5'd0; wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        exp_q.push_back(32'd0);
        #1;
        got = rd_data0; exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL bypass_zero_reg got=%h exp=%h", got, exp); end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr0 = '0; rd_addr1 = '0; clr_req = 1'b0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bulk_clear();
        test_reset_mid_sweep();
        test_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised register file: 1 write port, 2 asynchronous read ports, DEPTH x DATA_W storage.
- Write-enable fan-out comes from an internal parametrised one-hot decoder, generalising the fixed 5-to-32 decode.
- Adds a sequential bulk-clear engine (FSM sweep, one entry per cycle) and an optional write-to-read bypass.
- Sits in the reg_file datapath, between decode/writeback and operand fetch.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers; power of two, >= 2.
- ADDR_W, $clog2(DEPTH), address width; derived, never overridden.
- ZERO_REG, 1, when 1 entry 0 is hardwired to zero and writes to it are dropped.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_addr0  in  ADDR_W  read port 0 address.
- rd_data0  out  DATA_W  read port 0 data, combinational.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_data1  out  DATA_W  read port 1 data, combinational.
- clr_req  in  1  start bulk clear (sampled in IDLE only).
- clr_busy  out  1  clear sweep in progress.
- clr_done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (reset).
- On reset assertion:
  - All entries go to 0, the FSM goes to IDLE and the sweep pointer to 0.
  - clr_busy=0 and clr_done=0.
  - rd_data0/1 read 0 because all entries are 0.
- Write:
  - When wr_en=1 in IDLE, entry wr_addr takes wr_data at the rising edge and is visible on reads the next cycle.
  - The one-hot decode of wr_addr, gated by wr_en, selects exactly one entry. No entry changes without wr_en.
- ZERO_REG=1: a write to address 0 is discarded and reads of address 0 always return 0.
- Read: rd_dataN = entry[rd_addrN], combinational with 0-cycle latency. Both ports are independent and may use the same address.
- FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_req=1 -> CLEAR with pointer=0. Otherwise stay in IDLE.
  - CLEAR: each cycle entry[pointer] <- 0 and pointer increments. When pointer == DEPTH-1 that entry is cleared and the FSM moves to DONE. CLEAR lasts exactly DEPTH cycles. clr_busy=1 throughout.
  - DONE: clr_done=1 and clr_busy=0 for one cycle, then unconditionally IDLE.
- Boundary conditions:
  - wr_en=1 and clr_req=1 in the same IDLE cycle: the write is performed, and the sweep that follows still clears that entry.
  - wr_en during CLEAR or DONE: ignored, no entry changes.
  - clr_req during CLEAR or DONE: ignored; it is not queued.
  - Reads during CLEAR return live contents: already-swept entries read 0, unswept entries keep their old values.
  - Pointer width is ADDR_W. The terminal compare is used, never wrap-around, so no entry is swept twice.
  - Reset mid-sweep aborts immediately with all entries 0 and state IDLE; clr_done is not pulsed.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: when wr_en=1 in IDLE and rd_addrN == wr_addr (and the address is not 0 with ZERO_REG=1), rd_dataN = wr_data in the same cycle (write-to-read forwarding). Each port is forwarded independently.
- Undefined: same-cycle reads return the pre-write value; the new value appears the following cycle.

Decomposition:
- Package reg_file_pkg holds:
  - the FSM state enum (IDLE, CLEAR, DONE), 2-bit encoding;
  - default constants DATA_W_DEF=32 and DEPTH_DEF=32.
- Sub-module decoder_param (parameter N_SEL; inputs sel[N_SEL-1:0] and en; output onehot[2**N_SEL-1:0]) is combinational and is instantiated once for the write-enable vector.
- The clear pointer reuses the write-enable path by muxing the address into the decoder while in CLEAR.

Test Plan:
- Reset check: assert reset asynchronously mid-cycle -> all 32 entries read 0, clr_busy=0, clr_done=0.
- Write/read: write 0xDEADBEEF to addr 5 and 0x12345678 to addr 31 -> next cycle rd_addr0=5 gives 0xDEADBEEF and rd_addr1=31 gives 0x12345678; addr 6 still reads 0.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to addr 0 -> both ports read 0 at addr 0.
- Bulk clear: fill all entries with value=addr+1, pulse clr_req ->
  - clr_busy high for exactly 32 cycles, then clr_done high for 1 cycle;
  - on the 3rd busy cycle, addr 1 reads 0 and addr 10 reads 11;
  - after done, all entries read 0;
  - wr_en asserted during busy to addr 7 with 0xAA leaves addr 7 at 0.
- Reset mid-sweep: assert reset at sweep cycle 10 -> immediate IDLE, all entries 0, no clr_done pulse; a new clr_req afterwards runs a full 32-cycle sweep.
- Bypass: same-cycle write of 0xCAFEF00D to addr 9 with rd_addr0=9 -> rd_data0=0xCAFEF00D with REG_FILE_BYPASS_EN defined, old value without it.
